// File: rtl/actuator_phase_driver_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// actuator_pkg : shared phase codes, FSM encoding and default widths
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
package actuator_pkg;

   localparam int C_CELLS_DEFAULT = 16;
   localparam int C_CW_DEFAULT    = 32;

   localparam logic [2:0] C_PHASE_IDLE      = 3'd0;
   localparam logic [2:0] C_PHASE_PRECHARGE = 3'd1;
   localparam logic [2:0] C_PHASE_DRIVE     = 3'd2;
   localparam logic [2:0] C_PHASE_HOLD      = 3'd3;
   localparam logic [2:0] C_PHASE_RELEASE   = 3'd4;
   localparam logic [2:0] C_PHASE_FAULT     = 3'd7;

   localparam logic [1:0] C_ST_IDLE  = 2'd0;
   localparam logic [1:0] C_ST_RUN   = 2'd1;
   localparam logic [1:0] C_ST_FAULT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/actuator_phase_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// actuator_phase_driver_if : control/config inputs and drive outputs
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
interface actuator_phase_driver_if
   import actuator_pkg::*;
#(
   parameter int CELLS = C_CELLS_DEFAULT,
   parameter int CW    = C_CW_DEFAULT
);
   logic             enable;
   logic [CELLS-1:0] cell_state;
   logic [CW-1:0]    ccr0;
   logic [CW-1:0]    ccr1;
   logic [CW-1:0]    ccr2;
   logic [CW-1:0]    ccr3;
   logic [CELLS-1:0] drive_p;
   logic [CELLS-1:0] drive_n;
   logic [2:0]       phase;
   logic             busy;
   logic             period_done;
   logic             config_error;

   modport master (
      output enable, cell_state, ccr0, ccr1, ccr2, ccr3,
      input  drive_p, drive_n, phase, busy, period_done, config_error
   );

   modport slave (
      input  enable, cell_state, ccr0, ccr1, ccr2, ccr3,
      output drive_p, drive_n, phase, busy, period_done, config_error
   );
endinterface
`default_nettype wire

// File: rtl/actuator_phase_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// actuator_phase_decode : maps counter position against shadow bounds to
// phase code and complementary drive patterns (combinational)
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
module actuator_phase_decode
   import actuator_pkg::*;
#(
   parameter int CELLS = C_CELLS_DEFAULT,
   parameter int CW    = C_CW_DEFAULT
) (
   input  logic [CW-1:0]    i_cnt,
   input  logic [CW-1:0]    i_cmp0,
   input  logic [CW-1:0]    i_cmp1,
   input  logic [CW-1:0]    i_cmp2,
   input  logic [CELLS-1:0] i_cell_q,
   output logic [2:0]       o_phase,
   output logic [CELLS-1:0] o_drive_p,
   output logic [CELLS-1:0] o_drive_n
);

   // First match wins, so equal bounds collapse a phase to zero length.
   always_comb begin
      o_phase   = C_PHASE_RELEASE;
      o_drive_p = '0;
      o_drive_n = i_cell_q;
      if (i_cnt < i_cmp0) begin
         o_phase   = C_PHASE_PRECHARGE;
         o_drive_p = '0;
         o_drive_n = '0;
      end else if (i_cnt < i_cmp1) begin
         o_phase   = C_PHASE_DRIVE;
         o_drive_p = i_cell_q;
         o_drive_n = ~i_cell_q;
      end else if (i_cnt < i_cmp2) begin
         o_phase   = C_PHASE_HOLD;
         o_drive_p = i_cell_q;
         o_drive_n = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/actuator_phase_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// actuator_phase_driver : four-phase actuation period generator with
// configuration shadowed at period boundaries
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
module actuator_phase_driver
   import actuator_pkg::*;
#(
   parameter int CELLS = C_CELLS_DEFAULT,
   parameter int CW    = C_CW_DEFAULT
) (
   input  logic                     clock,
   input  logic                     reset_sn,
   actuator_phase_driver_if.slave   bus
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [CW-1:0]    r_cmp0;
   logic [CW-1:0]    r_cmp1;
   logic [CW-1:0]    r_cmp2;
   logic [CW-1:0]    r_cmp3;
   logic [CW-1:0]    w_cmp0_nxt;
   logic [CW-1:0]    w_cmp1_nxt;
   logic [CW-1:0]    w_cmp2_nxt;
   logic [CW-1:0]    w_cmp3_nxt;
   logic [CELLS-1:0] r_cell_q;
   logic [CELLS-1:0] w_cell_nxt;
   logic             r_config_error;
   logic             w_config_error_nxt;
   logic             w_load;
   logic             w_ordered;

   logic [2:0]       w_run_phase;
   logic [CELLS-1:0] w_run_drive_p;
   logic [CELLS-1:0] w_run_drive_n;

   logic [2:0]       w_phase_nxt;
   logic [CELLS-1:0] w_drive_p_nxt;
   logic [CELLS-1:0] w_drive_n_nxt;
   logic             w_busy_nxt;
   logic             w_period_done_nxt;

   logic [2:0]       r_phase;
   logic [CELLS-1:0] r_drive_p;
   logic [CELLS-1:0] r_drive_n;
   logic             r_busy;
   logic             r_period_done;

   // Ordering is checked on the live inputs because they become the shadows.
   assign w_ordered = (bus.ccr0 <= bus.ccr1) &&
                      (bus.ccr1 <= bus.ccr2) &&
                      (bus.ccr2 <= bus.ccr3);

   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_nxt          = r_cnt;
      w_cmp0_nxt         = r_cmp0;
      w_cmp1_nxt         = r_cmp1;
      w_cmp2_nxt         = r_cmp2;
      w_cmp3_nxt         = r_cmp3;
      w_cell_nxt         = r_cell_q;
      w_config_error_nxt = r_config_error;
      w_load             = 1'b0;

      case (r_state)
         C_ST_IDLE: begin
            w_load = bus.enable;
         end
         C_ST_RUN: begin
            if (r_cnt == r_cmp3) begin
               if (bus.enable) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = C_ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         C_ST_FAULT: begin
            if (!bus.enable) begin
               w_state_nxt        = C_ST_IDLE;
               w_config_error_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = C_ST_IDLE;
         end
      endcase

      if (w_load) begin
         w_cmp0_nxt = bus.ccr0;
         w_cmp1_nxt = bus.ccr1;
         w_cmp2_nxt = bus.ccr2;
         w_cmp3_nxt = bus.ccr3;
         w_cell_nxt = bus.cell_state;
         w_cnt_nxt  = '0;
         if (w_ordered) begin
            w_state_nxt = C_ST_RUN;
         end else begin
            w_state_nxt        = C_ST_FAULT;
            w_config_error_nxt = 1'b1;
         end
      end
   end

   // Decode the next-state position so the registered outputs line up with cnt.
   actuator_phase_decode #(
      .CELLS (CELLS),
      .CW    (CW)
   ) u_decode (
      .i_cnt     (w_cnt_nxt),
      .i_cmp0    (w_cmp0_nxt),
      .i_cmp1    (w_cmp1_nxt),
      .i_cmp2    (w_cmp2_nxt),
      .i_cell_q  (w_cell_nxt),
      .o_phase   (w_run_phase),
      .o_drive_p (w_run_drive_p),
      .o_drive_n (w_run_drive_n)
   );

   always_comb begin
      w_phase_nxt       = C_PHASE_IDLE;
      w_drive_p_nxt     = '0;
      w_drive_n_nxt     = '0;
      w_busy_nxt        = 1'b0;
      w_period_done_nxt = 1'b0;
      case (w_state_nxt)
         C_ST_RUN: begin
            w_phase_nxt       = w_run_phase;
            w_drive_p_nxt     = w_run_drive_p;
            w_drive_n_nxt     = w_run_drive_n;
            w_busy_nxt        = 1'b1;
            w_period_done_nxt = (w_cnt_nxt == w_cmp3_nxt);
         end
         C_ST_FAULT: begin
            w_phase_nxt = C_PHASE_FAULT;
         end
         default: begin
            w_phase_nxt = C_PHASE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_sn) begin
         r_state        <= C_ST_IDLE;
         r_cnt          <= '0;
         r_cmp0         <= '0;
         r_cmp1         <= '0;
         r_cmp2         <= '0;
         r_cmp3         <= '0;
         r_cell_q       <= '0;
         r_config_error <= 1'b0;
         r_phase        <= C_PHASE_IDLE;
         r_drive_p      <= '0;
         r_drive_n      <= '0;
         r_busy         <= 1'b0;
         r_period_done  <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_cmp0         <= w_cmp0_nxt;
         r_cmp1         <= w_cmp1_nxt;
         r_cmp2         <= w_cmp2_nxt;
         r_cmp3         <= w_cmp3_nxt;
         r_cell_q       <= w_cell_nxt;
         r_config_error <= w_config_error_nxt;
         r_phase        <= w_phase_nxt;
         r_drive_p      <= w_drive_p_nxt;
         r_drive_n      <= w_drive_n_nxt;
         r_busy         <= w_busy_nxt;
         r_period_done  <= w_period_done_nxt;
      end
   end

   assign bus.drive_p      = r_drive_p;
   assign bus.drive_n      = r_drive_n;
   assign bus.phase        = r_phase;
   assign bus.busy         = r_busy;
   assign bus.period_done  = r_period_done;
   assign bus.config_error = r_config_error;

endmodule
`default_nettype wire

// File: tb/tb_actuator_phase_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_actuator_phase_driver : directed scenarios plus randomized run against a
// period-level reference model
// Rev 1.0  initial release
// ---------------------------------------------------------------------------
module tb_actuator_phase_driver;
   import actuator_pkg::*;

   localparam int CELLS = 16;
   localparam int CW    = 32;
   localparam int OW    = 6 + 2 * CELLS;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FAULT = 2;

   logic clock    = 1'b0;
   logic reset_sn = 1'b0;
   always #5 clock = ~clock;

   actuator_phase_driver_if #(.CELLS(CELLS), .CW(CW)) dut_if ();

   actuator_phase_driver #(.CELLS(CELLS), .CW(CW)) dut (
      .clock    (clock),
      .reset_sn (reset_sn),
      .bus      (dut_if.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: which period position we are at and the config snapshot.
   int               m_mode;
   int unsigned      m_pos;
   int unsigned      m_c[4];
   logic [CELLS-1:0] m_cell;
   bit               m_err;

   task automatic model_reset();
      m_mode = M_IDLE;
      m_pos  = 0;
      m_c    = '{0, 0, 0, 0};
      m_cell = '0;
      m_err  = 1'b0;
   endtask

   task automatic model_step();
      bit load;
      bit ok;
      load = 1'b0;
      case (m_mode)
         M_IDLE: load = dut_if.enable;
         M_RUN: begin
            if (m_pos == m_c[3]) begin
               if (dut_if.enable) load = 1'b1;
               else m_mode = M_IDLE;
            end else begin
               m_pos++;
            end
         end
         default: begin
            if (!dut_if.enable) begin
               m_mode = M_IDLE;
               m_err  = 1'b0;
            end
         end
      endcase
      if (load) begin
         m_c    = '{dut_if.ccr0, dut_if.ccr1, dut_if.ccr2, dut_if.ccr3};
         m_cell = dut_if.cell_state;
         m_pos  = 0;
         ok     = 1'b1;
         for (int j = 0; j < 3; j++) if (m_c[j] > m_c[j+1]) ok = 1'b0;
         m_mode = ok ? M_RUN : M_FAULT;
         m_err  = !ok;
      end
   endtask

   function automatic logic [OW-1:0] model_out();
      logic [2:0]       ph;
      logic [CELLS-1:0] p;
      logic [CELLS-1:0] n;
      bit               done;
      int unsigned      len[4];
      int unsigned      acc;
      int               k;
      bit               found;
      ph = 3'd0; p = '0; n = '0; done = 1'b0;
      if (m_mode == M_FAULT) begin
         ph = 3'd7;
      end else if (m_mode == M_RUN) begin
         len = '{m_c[0], m_c[1] - m_c[0], m_c[2] - m_c[1], m_c[3] - m_c[2] + 1};
         acc = 0; k = 3; found = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (!found && m_pos < acc + len[j]) begin
               k = j; found = 1'b1;
            end
            acc += len[j];
         end
         ph = 3'(k + 1);
         case (k)
            0: begin p = '0;     n = '0;      end
            1: begin p = m_cell; n = ~m_cell; end
            2: begin p = m_cell; n = '0;      end
            default: begin p = '0; n = m_cell; end
         endcase
         done = (m_pos == m_c[3]);
      end
      return {ph, (m_mode == M_RUN), done, m_err, p, n};
   endfunction

   function automatic logic [OW-1:0] dut_out();
      return {dut_if.phase, dut_if.busy, dut_if.period_done, dut_if.config_error,
              dut_if.drive_p, dut_if.drive_n};
   endfunction

   task automatic tick();
      @(posedge clock);
      if (!reset_sn) model_reset();
      else model_step();
      #1;
   endtask

   task automatic set_cfg(input int unsigned a, b, c, d);
      dut_if.ccr0 = a; dut_if.ccr1 = b; dut_if.ccr2 = c; dut_if.ccr3 = d;
   endtask

   task automatic test_reset();
      reset_sn = 1'b0;
      dut_if.enable = 1'b0;
      dut_if.cell_state = '0;
      set_cfg(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (dut_out() !== '0) begin
            n_errors++;
            $display("FAIL reset cyc=%0d act=%h exp=0", i, dut_out());
         end
      end
      reset_sn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [OW-1:0] exp;
      int            c;
      set_cfg(2, 5, 8, 10);
      dut_if.cell_state = 16'h00A5;
      dut_if.enable = 1'b1;
      for (int i = 0; i < 22; i++) begin
         tick();
         c = i % 11;
         exp[OW-1 -: 3] = (c < 2) ? 3'd1 : (c < 5) ? 3'd2 : (c < 8) ? 3'd3 : 3'd4;
         exp[OW-4]      = 1'b1;
         exp[OW-5]      = (c == 10);
         exp[OW-6]      = 1'b0;
         exp[2*CELLS-1 -: CELLS] = (c >= 2 && c < 8) ? 16'h00A5 : 16'h0000;
         exp[CELLS-1:0] = (c >= 2 && c < 5) ? 16'hFF5A : (c >= 8) ? 16'h00A5 : 16'h0000;
         n_checks++;
         if (dut_out() !== exp) begin
            n_errors++;
            $display("FAIL basic cyc=%0d act=%h exp=%h", i, dut_out(), exp);
         end
      end
   endtask

   task automatic test_mid_write();
      logic [CELLS-1:0] exp_p;
      int               c;
      for (int i = 0; i < 22; i++) begin
         tick();
         c = i % 11;
         exp_p = (c >= 2 && c < 8) ? ((i < 11) ? 16'h00A5 : 16'h0F0F) : 16'h0000;
         n_checks++;
         if (dut_if.drive_p !== exp_p || dut_out() !== model_out()) begin
            n_errors++;
            $display("FAIL mid_write cyc=%0d drive_p=%h exp=%h act=%h model=%h",
                     i, dut_if.drive_p, exp_p, dut_out(), model_out());
         end
         if (i == 3) dut_if.cell_state = 16'h0F0F;
      end
   endtask

   task automatic test_graceful_stop();
      bit exp_busy;
      for (int i = 0; i < 14; i++) begin
         tick();
         exp_busy = (i <= 10);
         n_checks++;
         if (dut_if.busy !== exp_busy || dut_if.period_done !== (i == 10) ||
             (!exp_busy && (dut_if.drive_p !== '0 || dut_if.drive_n !== '0 || dut_if.phase !== 3'd0))) begin
            n_errors++;
            $display("FAIL graceful_stop cyc=%0d busy=%b exp_busy=%b done=%b act=%h",
                     i, dut_if.busy, exp_busy, dut_if.period_done, dut_out());
         end
         if (i == 4) dut_if.enable = 1'b0;
      end
   endtask

   task automatic test_config_fault();
      set_cfg(6, 3, 8, 10);
      dut_if.enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (dut_if.config_error !== 1'b1 || dut_if.phase !== 3'd7 || dut_if.busy !== 1'b0 ||
             dut_if.drive_p !== '0 || dut_if.drive_n !== '0) begin
            n_errors++;
            $display("FAIL fault cyc=%0d err=%b phase=%0d act=%h", i, dut_if.config_error,
                     dut_if.phase, dut_out());
         end
      end
      dut_if.enable = 1'b0;
      tick();
      n_checks++;
      if (dut_out() !== '0) begin
         n_errors++;
         $display("FAIL fault_clear act=%h exp=0", dut_out());
      end
   endtask

   task automatic test_reset_mid_run();
      set_cfg(2, 5, 8, 10);
      dut_if.cell_state = 16'h00A5;
      dut_if.enable = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      reset_sn = 1'b0;
      tick();
      n_checks++;
      if (dut_out() !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_run act=%h exp=0", dut_out());
      end
      reset_sn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (dut_if.phase !== ((i < 2) ? 3'd1 : 3'd2) || dut_if.busy !== 1'b1 ||
             dut_if.drive_p !== ((i < 2) ? 16'h0000 : 16'h00A5)) begin
            n_errors++;
            $display("FAIL restart cyc=%0d phase=%0d busy=%b drive_p=%h", i, dut_if.phase,
                     dut_if.busy, dut_if.drive_p);
         end
      end
   endtask

   task automatic test_degenerate();
      logic [CELLS-1:0] prev;
      bool_wait: begin
         bit idle_seen;
         idle_seen = 1'b0;
         dut_if.enable = 1'b0;
         for (int i = 0; i < 20 && !idle_seen; i++) begin
            tick();
            if (dut_if.busy === 1'b0) idle_seen = 1'b1;
         end
         n_checks++;
         if (!idle_seen) begin
            n_errors++;
            $display("FAIL degenerate_wait busy=%b exp=0 (timeout)", dut_if.busy);
         end
      end
      set_cfg(0, 0, 0, 0);
      dut_if.enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         prev = CELLS'($urandom);
         dut_if.cell_state = prev;
         tick();
         n_checks++;
         if (dut_if.phase !== 3'd4 || dut_if.drive_n !== prev || dut_if.drive_p !== '0 ||
             dut_if.period_done !== 1'b1) begin
            n_errors++;
            $display("FAIL degenerate cyc=%0d phase=%0d drive_n=%h exp=%h done=%b",
                     i, dut_if.phase, dut_if.drive_n, prev, dut_if.period_done);
         end
      end
   endtask

   task automatic test_random();
      int unsigned v[4];
      int unsigned t;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            for (int j = 0; j < 4; j++) v[j] = $urandom_range(0, 12);
            if ($urandom_range(0, 9) < 7) begin
               for (int a = 0; a < 3; a++)
                  for (int b = 0; b < 3 - a; b++)
                     if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
            end
            set_cfg(v[0], v[1], v[2], v[3]);
         end
         if ($urandom_range(0, 19) == 0) dut_if.enable = ~dut_if.enable;
         if ($urandom_range(0, 4) == 0) dut_if.cell_state = CELLS'($urandom);
         reset_sn = ($urandom_range(0, 199) != 0);
         tick();
         n_checks++;
         if (dut_out() !== model_out() || (dut_if.drive_p & dut_if.drive_n) !== '0) begin
            n_errors++;
            $display("FAIL random cyc=%0d act=%h exp=%h", i, dut_out(), model_out());
         end
      end
      reset_sn = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_mid_write();
      test_graceful_stop();
      test_config_fault();
      test_reset_mid_run();
      test_degenerate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
